ngc_counter_sequencer: RTL and testbench

- Master-side controller for the ngc counter interface. It drives the counter's control and configuration inputs and consumes its count and count_hit outputs.
- Accepts one run command per transaction over a valid/ready handshake. For each command it clears the counter, loads it, enables it, and counts count_hit events until a programmed hit total, a one-shot hit or an abort.
- Reports completion with done/aborted pulses, the hit total and the final count value.

---
 rtl/ngc_counter_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ngc_counter_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ngc_counter_sequencer.sv
// Master-side sequencer for the ngc counter: clear, load, enable, then count hits until target/one-shot/abort.
// Optional RUN watchdog is built when NGC_COUNTER_SEQ_TIMEOUT_EN is defined; otherwise `timeout` is tied 0.
module ngc_counter_sequencer #(
  parameter int WIDTH          = 8,
  parameter int HIT_W          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic                 cmd_one_shot,
  input  logic [WIDTH-1:0]     cmd_start,
  input  logic [WIDTH-1:0]     cmd_from,
  input  logic [WIDTH-1:0]     cmd_to,
  input  logic [WIDTH/2-1:0]   cmd_step,
  input  logic [HIT_W-1:0]     cmd_hits,
  input  logic                 abort,
  output logic                 cnt_rst,
  output logic                 cnt_load,
  output logic                 cnt_enb,
  output logic                 cnt_dir,
  output logic                 cnt_one_shot,
  output logic [WIDTH-1:0]     cnt_load_value,
  output logic [WIDTH-1:0]     cnt_count_to_value,
  output logic [WIDTH-1:0]     cnt_count_from_value,
  output logic [WIDTH/2-1:0]   cnt_step_value,
  input  logic [WIDTH-1:0]     cnt_count,
  input  logic                 cnt_count_hit,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 timeout,
  output logic [HIT_W-1:0]     hit_cnt,
  output logic [WIDTH-1:0]     last_count,
  output logic [2:0]           fsm_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  if ((WIDTH % 2) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ngc_counter_sequencer: WIDTH must be even and TIMEOUT_CYCLES >= 1");
  end

  // Handshake: a command transfers on any posedge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly in IDLE, and cmd_valid may be held while busy.
  logic [2:0]         state;
  logic               dir_q;
  logic               one_shot_q;
  logic [WIDTH-1:0]   start_q;
  logic [WIDTH-1:0]   from_q;
  logic [WIDTH-1:0]   to_q;
  logic [WIDTH/2-1:0] step_q;
  logic [HIT_W-1:0]   hits_q;
  logic [HIT_W-1:0]   hit_cnt_q;
  logic [WIDTH-1:0]   last_q;
  logic               ab_q;

  logic               accept;
  logic               in_run;
  logic               hit_term;
  logic               to_fire;
  logic               term;
  logic [HIT_W:0]     hit_next;

  assign accept   = (state == S_IDLE) && cmd_valid;
  assign in_run   = (state == S_RUN);
  assign hit_next = {1'b0, hit_cnt_q} + (HIT_W+1)'(1);
  // A terminal hit takes priority over a simultaneous abort or watchdog expiry.
  assign hit_term = cnt_count_hit &&
                    (one_shot_q || ((hits_q != '0) && (hit_next == {1'b0, hits_q})));
  assign term     = in_run && (abort || hit_term || to_fire);

`ifdef NGC_COUNTER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;
  logic          to_flag_q;

  // Expires on the TIMEOUT_CYCLES-th RUN cycle since entry or since the latest hit.
  assign to_fire = in_run && !cnt_count_hit && (wd_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout = (state == S_DONE) && to_flag_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q      <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (state == S_LOAD || (in_run && cnt_count_hit))
        wd_q <= '0;
      else if (in_run)
        wd_q <= wd_q + TW'(1);
      if (term)
        to_flag_q <= to_fire && !abort;
      else if (state == S_DONE)
        to_flag_q <= 1'b0;
    end
  end
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      start_q    <= '0;
      from_q     <= '0;
      to_q       <= '0;
      step_q     <= '0;
      hits_q     <= '0;
      hit_cnt_q  <= '0;
      last_q     <= '0;
      ab_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dir_q      <= cmd_dir;
            one_shot_q <= cmd_one_shot;
            start_q    <= cmd_start;
            from_q     <= cmd_from;
            to_q       <= cmd_to;
            step_q     <= cmd_step;
            hits_q     <= cmd_hits;
            hit_cnt_q  <= '0;
            state      <= S_CLR;
          end
        end
        S_CLR:  state <= S_LOAD;
        S_LOAD: state <= S_RUN;
        S_RUN: begin
          if (cnt_count_hit && (hit_cnt_q != {HIT_W{1'b1}}))
            hit_cnt_q <= hit_next[HIT_W-1:0];
          if (term) begin
            ab_q  <= !hit_term;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          last_q <= cnt_count;
          ab_q   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready            = (state == S_IDLE);
  assign busy                 = (state != S_IDLE);
  assign cnt_rst              = (state == S_CLR);
  assign cnt_load             = (state == S_LOAD);
  assign cnt_enb              = in_run && !term;
  assign done                 = (state == S_DONE);
  assign aborted              = (state == S_DONE) && ab_q;
  assign cnt_dir              = dir_q;
  assign cnt_one_shot         = one_shot_q;
  assign cnt_load_value       = start_q;
  assign cnt_count_from_value = from_q;
  assign cnt_count_to_value   = to_q;
  assign cnt_step_value       = step_q;
  assign hit_cnt              = hit_cnt_q;
  assign last_count           = last_q;
  assign fsm_state            = state;

endmodule

// File: tb/tb_ngc_counter_sequencer.sv
// Directed self-checking bench for ngc_counter_sequencer; the counter is emulated by driving cnt_count/cnt_count_hit.
module tb_ngc_counter_sequencer;

  localparam int WIDTH = 8;
  localparam int HIT_W = 4;
  localparam int TO    = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic               cmd_one_shot;
  logic [WIDTH-1:0]   cmd_start;
  logic [WIDTH-1:0]   cmd_from;
  logic [WIDTH-1:0]   cmd_to;
  logic [WIDTH/2-1:0] cmd_step;
  logic [HIT_W-1:0]   cmd_hits;
  logic               abort;
  logic               cnt_rst;
  logic               cnt_load;
  logic               cnt_enb;
  logic               cnt_dir;
  logic               cnt_one_shot;
  logic [WIDTH-1:0]   cnt_load_value;
  logic [WIDTH-1:0]   cnt_count_to_value;
  logic [WIDTH-1:0]   cnt_count_from_value;
  logic [WIDTH/2-1:0] cnt_step_value;
  logic [WIDTH-1:0]   cnt_count;
  logic               cnt_count_hit;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               timeout;
  logic [HIT_W-1:0]   hit_cnt;
  logic [WIDTH-1:0]   last_count;
  logic [2:0]         fsm_state;

  int checks = 0;
  int errors = 0;

  ngc_counter_sequencer #(
    .WIDTH(WIDTH), .HIT_W(HIT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_one_shot(cmd_one_shot),
    .cmd_start(cmd_start), .cmd_from(cmd_from), .cmd_to(cmd_to),
    .cmd_step(cmd_step), .cmd_hits(cmd_hits), .abort(abort),
    .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_enb(cnt_enb),
    .cnt_dir(cnt_dir), .cnt_one_shot(cnt_one_shot),
    .cnt_load_value(cnt_load_value), .cnt_count_to_value(cnt_count_to_value),
    .cnt_count_from_value(cnt_count_from_value), .cnt_step_value(cnt_step_value),
    .cnt_count(cnt_count), .cnt_count_hit(cnt_count_hit),
    .busy(busy), .done(done), .aborted(aborted), .timeout(timeout),
    .hit_cnt(hit_cnt), .last_count(last_count), .fsm_state(fsm_state)
  );

  // Clock and global time bound
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench time limit reached");
  end

  // Driver tasks: inputs change 1ns after posedge, outputs are sampled at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic dir, input logic one_shot, input logic [WIDTH-1:0] start,
                          input logic [WIDTH-1:0] from, input logic [WIDTH-1:0] to,
                          input logic [WIDTH/2-1:0] step, input logic [HIT_W-1:0] hits);
    tick();
    cmd_dir      = dir;
    cmd_one_shot = one_shot;
    cmd_start    = start;
    cmd_from     = from;
    cmd_to       = to;
    cmd_step     = step;
    cmd_hits     = hits;
    cmd_valid    = 1'b1;
    tick();
    cmd_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b1; abort = 1'b0;
    cmd_dir = 1'b1; cmd_one_shot = 1'b1; cmd_start = 8'hAA; cmd_from = 8'h11;
    cmd_to = 8'h22; cmd_step = 4'h3; cmd_hits = 4'h7;
    cnt_count = '0; cnt_count_hit = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0h exp 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++;
    if ({cnt_rst, cnt_load, cnt_enb, cnt_dir, cnt_one_shot} !== 5'b0) begin
      errors++; $display("FAIL reset_cnt_ctrl got %b exp 00000", {cnt_rst, cnt_load, cnt_enb, cnt_dir, cnt_one_shot});
    end
    checks++;
    if ({cnt_load_value, cnt_count_from_value, cnt_count_to_value, cnt_step_value} !== 28'h0) begin
      errors++; $display("FAIL reset_cnt_cfg got %h exp 0",
        {cnt_load_value, cnt_count_from_value, cnt_count_to_value, cnt_step_value});
    end
    checks++;
    if ({done, aborted, timeout, hit_cnt, last_count} !== 15'h0) begin
      errors++; $display("FAIL reset_status got %h exp 0", {done, aborted, timeout, hit_cnt, last_count});
    end
    tick();
    rst = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %0h exp 0", busy); end
  endtask

  task automatic test_basic_run();
    send_cmd(1'b1, 1'b0, 8'h00, 8'h00, 8'h09, 4'h1, 4'd2);
    @(negedge clk);
    checks++; if (cnt_rst !== 1'b1 || cnt_enb !== 1'b0 || cnt_load !== 1'b0) begin
      errors++; $display("FAIL basic_clr got rst=%0h load=%0h enb=%0h exp 1 0 0", cnt_rst, cnt_load, cnt_enb); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy got ready=%0h busy=%0h exp 0 1", cmd_ready, busy); end
    checks++; if (cnt_dir !== 1'b1 || cnt_count_to_value !== 8'h09 || cnt_step_value !== 4'h1) begin
      errors++; $display("FAIL basic_cfg got dir=%0h to=%0h step=%0h exp 1 9 1", cnt_dir, cnt_count_to_value, cnt_step_value); end
    tick();
    @(negedge clk);
    checks++; if (cnt_load !== 1'b1 || cnt_rst !== 1'b0 || cnt_enb !== 1'b0 || cnt_load_value !== 8'h00) begin
      errors++; $display("FAIL basic_load got load=%0h rst=%0h enb=%0h val=%0h exp 1 0 0 0",
        cnt_load, cnt_rst, cnt_enb, cnt_load_value); end
    tick();
    cnt_count = 8'h00;
    @(negedge clk);
    checks++; if (cnt_enb !== 1'b1 || cnt_load !== 1'b0) begin
      errors++; $display("FAIL basic_first_enb got enb=%0h load=%0h exp 1 0", cnt_enb, cnt_load); end
    for (int i = 1; i <= 3; i++) begin tick(); cnt_count = WIDTH'(i); end
    cnt_count_hit = 1'b1;
    @(negedge clk);
    checks++; if (cnt_enb !== 1'b1) begin errors++; $display("FAIL basic_first_hit_enb got %0h exp 1", cnt_enb); end
    tick(); cnt_count_hit = 1'b0; cnt_count = 8'h05;
    tick(); cnt_count = 8'h09; cnt_count_hit = 1'b1;
    @(negedge clk);
    checks++; if (cnt_enb !== 1'b0) begin errors++; $display("FAIL basic_term_enb got %0h exp 0", cnt_enb); end
    tick(); cnt_count_hit = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || aborted !== 1'b0 || hit_cnt !== 4'd2) begin
      errors++; $display("FAIL basic_done got done=%0h ab=%0h hits=%0d exp 1 0 2", done, aborted, hit_cnt); end
    tick();
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || last_count !== 8'h09 || hit_cnt !== 4'd2) begin
      errors++; $display("FAIL basic_idle got done=%0h busy=%0h ready=%0h last=%0h hits=%0d exp 0 0 1 9 2",
        done, busy, cmd_ready, last_count, hit_cnt); end
  endtask

  task automatic test_one_shot();
    send_cmd(1'b0, 1'b1, 8'h10, 8'h10, 8'h02, 4'h2, 4'd5);
    tick();
    @(negedge clk);
    checks++; if (cnt_load_value !== 8'h10 || cnt_one_shot !== 1'b1 || cnt_dir !== 1'b0) begin
      errors++; $display("FAIL one_shot_cfg got val=%0h os=%0h dir=%0h exp 10 1 0", cnt_load_value, cnt_one_shot, cnt_dir); end
    tick(); cnt_count = 8'h10;
    tick(); cnt_count = 8'h0E; cnt_count_hit = 1'b1;
    @(negedge clk);
    checks++; if (cnt_enb !== 1'b0) begin errors++; $display("FAIL one_shot_term_enb got %0h exp 0", cnt_enb); end
    tick(); cnt_count_hit = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || aborted !== 1'b0 || hit_cnt !== 4'd1) begin
      errors++; $display("FAIL one_shot_done got done=%0h ab=%0h hits=%0d exp 1 0 1", done, aborted, hit_cnt); end
    tick();
    @(negedge clk);
    checks++; if (last_count !== 8'h0E) begin errors++; $display("FAIL one_shot_last got %0h exp e", last_count); end
  endtask

  task automatic test_abort();
    send_cmd(1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 4'h1, 4'd0);
    tick();
    tick();
    // RUN cycles 1..19: hits on 2..18 (17 hits) must saturate hit_cnt at 15 and never end the run
    for (int i = 1; i <= 19; i++) begin
      cnt_count = WIDTH'(i);
      cnt_count_hit = (i >= 2 && i <= 18);
      @(negedge clk);
      if (i == 10 || i == 18) begin
        checks++; if (cnt_enb !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL abort_run_enb_%0d got enb=%0h busy=%0h exp 1 1", i, cnt_enb, busy); end
      end
      tick();
    end
    cnt_count_hit = 1'b0; cnt_count = 8'h55; abort = 1'b1;
    @(negedge clk);
    checks++; if (cnt_enb !== 1'b0) begin errors++; $display("FAIL abort_enb got %0h exp 0", cnt_enb); end
    tick(); abort = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || aborted !== 1'b1 || hit_cnt !== 4'd15) begin
      errors++; $display("FAIL abort_done got done=%0h ab=%0h hits=%0d exp 1 1 15", done, aborted, hit_cnt); end
    tick(); abort = 1'b1;
    @(negedge clk);
    checks++; if (last_count !== 8'h55) begin errors++; $display("FAIL abort_last got %0h exp 55", last_count); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || cmd_ready !== 1'b1 || cnt_enb !== 1'b0) begin
      errors++; $display("FAIL abort_idle_ignored got busy=%0h done=%0h ab=%0h ready=%0h enb=%0h exp 0 0 0 1 0",
        busy, done, aborted, cmd_ready, cnt_enb); end
    tick(); abort = 1'b0;
  endtask

  task automatic test_abort_hit_priority();
    send_cmd(1'b1, 1'b0, 8'h03, 8'h01, 8'h20, 4'h4, 4'd1);
    tick();
    tick(); cnt_count = 8'h03;
    // A second command is offered and held while the first run is still busy
    cmd_dir = 1'b0; cmd_one_shot = 1'b0; cmd_start = 8'h40; cmd_from = 8'h30;
    cmd_to = 8'h33; cmd_step = 4'h5; cmd_hits = 4'd3; cmd_valid = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0 || cnt_count_to_value !== 8'h20 || cnt_step_value !== 4'h4) begin
      errors++; $display("FAIL prio_hold_cfg got ready=%0h to=%0h step=%0h exp 0 20 4",
        cmd_ready, cnt_count_to_value, cnt_step_value); end
    tick(); cnt_count = 8'h07; cnt_count_hit = 1'b1; abort = 1'b1;
    @(negedge clk);
    checks++; if (cnt_enb !== 1'b0) begin errors++; $display("FAIL prio_term_enb got %0h exp 0", cnt_enb); end
    tick(); cnt_count_hit = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || aborted !== 1'b0 || hit_cnt !== 4'd1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL prio_done got done=%0h ab=%0h hits=%0d ready=%0h exp 1 0 1 0",
        done, aborted, hit_cnt, cmd_ready); end
    tick();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || cnt_count_to_value !== 8'h20 || last_count !== 8'h07) begin
      errors++; $display("FAIL prio_idle got ready=%0h to=%0h last=%0h exp 1 20 7",
        cmd_ready, cnt_count_to_value, last_count); end
    tick(); cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (cnt_rst !== 1'b1 || cnt_dir !== 1'b0 || cnt_count_to_value !== 8'h33 ||
                  cnt_count_from_value !== 8'h30 || hit_cnt !== 4'd0) begin
      errors++; $display("FAIL prio_held_accept got rst=%0h dir=%0h to=%0h from=%0h hits=%0d exp 1 0 33 30 0",
        cnt_rst, cnt_dir, cnt_count_to_value, cnt_count_from_value, hit_cnt); end
    tick();
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || aborted !== 1'b1) begin
      errors++; $display("FAIL prio_second_abort got done=%0h ab=%0h exp 1 1", done, aborted); end
    tick();
  endtask

  task automatic test_timeout();
    send_cmd(1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 4'h1, 4'd0);
    tick();
    tick();
    for (int i = 1; i < TO; i++) begin
      cnt_count = WIDTH'(i);
      tick();
    end
    @(negedge clk);
`ifdef NGC_COUNTER_SEQ_TIMEOUT_EN
    checks++; if (cnt_enb !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_term got enb=%0h to=%0h exp 0 0", cnt_enb, timeout); end
    tick();
    @(negedge clk);
    checks++; if (done !== 1'b1 || aborted !== 1'b1 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_done got done=%0h ab=%0h to=%0h exp 1 1 1", done, aborted, timeout); end
    tick();
`else
    checks++; if (cnt_enb !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_off_run got enb=%0h to=%0h exp 1 0", cnt_enb, timeout); end
    tick();
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_off_cont got done=%0h busy=%0h to=%0h exp 0 1 0", done, busy, timeout); end
    abort = 1'b1;
    tick(); abort = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || aborted !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_off_abort got done=%0h ab=%0h to=%0h exp 1 1 0", done, aborted, timeout); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_run();
    send_cmd(1'b1, 1'b0, 8'h00, 8'h00, 8'h09, 4'h1, 4'd4);
    tick();
    tick(); cnt_count_hit = 1'b1;
    tick(); cnt_count_hit = 1'b0; rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cnt_enb !== 1'b0 || hit_cnt !== 4'd0) begin
      errors++; $display("FAIL mid_reset got busy=%0h done=%0h enb=%0h hits=%0d exp 0 0 0 0",
        busy, done, cnt_enb, hit_cnt); end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_after got done=%0h ready=%0h exp 0 1", done, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_one_shot();
    test_abort();
    test_abort_hit_priority();
    test_timeout();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
